// File: rtl/nn_mem_loader.sv
// rtl/nn_mem_loader.sv - stream-fed write loader for KMEM and the WMEM1/WMEM2 weight memories
module nn_mem_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int KR_WR  = 1,
    parameter int W_WR   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] kmem_add1_o,
    output logic [ADDR_W-1:0] kmem_add2_o,
    output logic              kmem_csb1_o,
    output logic              kmem_csb2_o,
    output logic              kmem_web1_o,
    output logic              kmem_web2_o,
    output logic              kmem_oeb1_o,
    output logic              kmem_oeb2_o,
    output logic [DATA_W-1:0] kr_data_i1_o,
    output logic [DATA_W-1:0] kr_data_i2_o,
    output logic [ADDR_W-1:0] wmem_add1_o,
    output logic [ADDR_W-1:0] wmem_add2_o,
    output logic              wmem_csb1_o,
    output logic              wmem_csb2_o,
    output logic              wmem_web1_o,
    output logic              wmem_web2_o,
    output logic              wmem_oeb1_o,
    output logic              wmem_oeb2_o,
    output logic [DATA_W-1:0] w1_data_i1_o,
    output logic [DATA_W-1:0] w1_data_i2_o,
    output logic [DATA_W-1:0] w2_data_i1_o,
    output logic [DATA_W-1:0] w2_data_i2_o
);
    localparam int GW = ADDR_W - 1;
    localparam logic [GW-1:0] KR_LAST = GW'(KR_WR - 1);
    localparam logic [GW-1:0] W_LAST  = GW'(W_WR - 1);

    typedef enum logic [1:0] {S_IDLE, S_KR, S_W, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              wr_q;
    logic              kwr_q, wwr_q;
    logic [1:0]        beat_q;
    logic [GW-1:0]     grp_q;
    logic [ADDR_W-1:0] kadd1_q, kadd2_q, wadd1_q, wadd2_q;
    logic [DATA_W-1:0] kd1_q, kd2_q, w1d1_q, w1d2_q, w2d1_q, w2d2_q;
    logic              beat;
    logic              last_beat;

    assign beat      = in_valid_i & in_ready_o;
    assign last_beat = (state_q == S_KR) ? (beat_q == 2'd1) : (beat_q == 2'd3);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            kwr_q   <= 1'b0;
            wwr_q   <= 1'b0;
            beat_q  <= '0;
            grp_q   <= '0;
            kadd1_q <= '0;
            kadd2_q <= '0;
            wadd1_q <= '0;
            wadd2_q <= '0;
            kd1_q   <= '0;
            kd2_q   <= '0;
            w1d1_q  <= '0;
            w1d2_q  <= '0;
            w2d1_q  <= '0;
            w2d2_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= 1'b0;
            kwr_q   <= 1'b0;
            wwr_q   <= 1'b0;
            if (beat) begin
                if (state_q == S_KR) begin
                    if (beat_q == 2'd0) kd1_q <= in_data_i;
                    else                kd2_q <= in_data_i;
                end else begin
                    case (beat_q)
                        2'd0:    w1d1_q <= in_data_i;
                        2'd1:    w1d2_q <= in_data_i;
                        2'd2:    w2d1_q <= in_data_i;
                        default: w2d2_q <= in_data_i;
                    endcase
                end
                if (last_beat) begin
                    beat_q <= '0;
                    wr_q   <= 1'b1;
                    if (state_q == S_KR) begin
                        kwr_q   <= 1'b1;
                        kadd1_q <= {grp_q, 1'b0};
                        kadd2_q <= {grp_q, 1'b1};
                    end else begin
                        wwr_q   <= 1'b1;
                        wadd1_q <= {grp_q, 1'b0};
                        wadd2_q <= {grp_q, 1'b1};
                    end
                end else begin
                    beat_q <= beat_q + 2'd1;
                end
            end
            // Group index advances after each write cycle and restarts on every region change.
            if (wr_q) grp_q <= (state_d != state_q) ? '0 : grp_q + GW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_KR;
            S_KR:    if (wr_q && grp_q == KR_LAST) state_d = S_W;
            S_W:     if (wr_q && grp_q == W_LAST) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q == S_KR) || (state_q == S_W);
        in_ready_o   = busy_o && !wr_q;
        done_o       = (state_q == S_DONE);
        kmem_add1_o  = kadd1_q;
        kmem_add2_o  = kadd2_q;
        kmem_csb1_o  = ~kwr_q;
        kmem_csb2_o  = ~kwr_q;
        kmem_web1_o  = ~kwr_q;
        kmem_web2_o  = ~kwr_q;
        kmem_oeb1_o  = 1'b1;
        kmem_oeb2_o  = 1'b1;
        kr_data_i1_o = kd1_q;
        kr_data_i2_o = kd2_q;
        wmem_add1_o  = wadd1_q;
        wmem_add2_o  = wadd2_q;
        wmem_csb1_o  = ~wwr_q;
        wmem_csb2_o  = ~wwr_q;
        wmem_web1_o  = ~wwr_q;
        wmem_web2_o  = ~wwr_q;
        wmem_oeb1_o  = 1'b1;
        wmem_oeb2_o  = 1'b1;
        w1_data_i1_o = w1d1_q;
        w1_data_i2_o = w1d2_q;
        w2_data_i1_o = w2d1_q;
        w2_data_i2_o = w2d2_q;
    end
endmodule

// File: tb/tb_nn_mem_loader.sv
// tb/tb_nn_mem_loader.sv - directed bench for nn_mem_loader with W_WR=2 and W_WR=16 instances
module tb_nn_mem_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] data = '0;
    logic        sel_b = 1'b0;
    logic        mdl_clr = 1'b0;
    int          vec_cnt = 0;
    int          err_cnt = 0;
    int          cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Instance A: W_WR=2
    logic a_ready, a_busy, a_done;
    logic [4:0] a_kadd1, a_kadd2, a_wadd1, a_wadd2;
    logic a_kcsb1, a_kcsb2, a_kweb1, a_kweb2, a_koeb1, a_koeb2;
    logic a_wcsb1, a_wcsb2, a_wweb1, a_wweb2, a_woeb1, a_woeb2;
    logic [31:0] a_kd1, a_kd2, a_w1d1, a_w1d2, a_w2d1, a_w2d2;

    nn_mem_loader #(.DATA_W(32), .ADDR_W(5), .KR_WR(1), .W_WR(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start & ~sel_b), .in_valid_i(valid & ~sel_b),
        .in_data_i(data), .in_ready_o(a_ready), .busy_o(a_busy), .done_o(a_done),
        .kmem_add1_o(a_kadd1), .kmem_add2_o(a_kadd2),
        .kmem_csb1_o(a_kcsb1), .kmem_csb2_o(a_kcsb2), .kmem_web1_o(a_kweb1), .kmem_web2_o(a_kweb2),
        .kmem_oeb1_o(a_koeb1), .kmem_oeb2_o(a_koeb2), .kr_data_i1_o(a_kd1), .kr_data_i2_o(a_kd2),
        .wmem_add1_o(a_wadd1), .wmem_add2_o(a_wadd2),
        .wmem_csb1_o(a_wcsb1), .wmem_csb2_o(a_wcsb2), .wmem_web1_o(a_wweb1), .wmem_web2_o(a_wweb2),
        .wmem_oeb1_o(a_woeb1), .wmem_oeb2_o(a_woeb2),
        .w1_data_i1_o(a_w1d1), .w1_data_i2_o(a_w1d2), .w2_data_i1_o(a_w2d1), .w2_data_i2_o(a_w2d2)
    );

    // Instance B: W_WR=16
    logic b_ready, b_busy, b_done;
    logic [4:0] b_kadd1, b_kadd2, b_wadd1, b_wadd2;
    logic b_kcsb1, b_kcsb2, b_kweb1, b_kweb2, b_koeb1, b_koeb2;
    logic b_wcsb1, b_wcsb2, b_wweb1, b_wweb2, b_woeb1, b_woeb2;
    logic [31:0] b_kd1, b_kd2, b_w1d1, b_w1d2, b_w2d1, b_w2d2;

    nn_mem_loader #(.DATA_W(32), .ADDR_W(5), .KR_WR(1), .W_WR(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start & sel_b), .in_valid_i(valid & sel_b),
        .in_data_i(data), .in_ready_o(b_ready), .busy_o(b_busy), .done_o(b_done),
        .kmem_add1_o(b_kadd1), .kmem_add2_o(b_kadd2),
        .kmem_csb1_o(b_kcsb1), .kmem_csb2_o(b_kcsb2), .kmem_web1_o(b_kweb1), .kmem_web2_o(b_kweb2),
        .kmem_oeb1_o(b_koeb1), .kmem_oeb2_o(b_koeb2), .kr_data_i1_o(b_kd1), .kr_data_i2_o(b_kd2),
        .wmem_add1_o(b_wadd1), .wmem_add2_o(b_wadd2),
        .wmem_csb1_o(b_wcsb1), .wmem_csb2_o(b_wcsb2), .wmem_web1_o(b_wweb1), .wmem_web2_o(b_wweb2),
        .wmem_oeb1_o(b_woeb1), .wmem_oeb2_o(b_woeb2),
        .w1_data_i1_o(b_w1d1), .w1_data_i2_o(b_w1d2), .w2_data_i1_o(b_w2d1), .w2_data_i2_o(b_w2d2)
    );

    // Memory models: capture on the edge that ends a strobed cycle
    logic [31:0] a_km[32], a_w1[32], a_w2[32];
    int          a_wcnt[32];
    int          a_kcnt, a_wtot, a_last_w, a_done_cnt, a_done_cyc, a_viol;
    logic [31:0] b_km[32], b_w1[32], b_w2[32];
    int          b_wcnt[32];
    int          b_kcnt, b_wtot, b_last_w, b_done_cnt, b_done_cyc, b_viol;

    always @(posedge clk) begin
        if (mdl_clr) begin
            for (int i = 0; i < 32; i++) begin
                a_km[i] <= '0; a_w1[i] <= '0; a_w2[i] <= '0; a_wcnt[i] <= 0;
            end
            a_kcnt <= 0; a_wtot <= 0; a_last_w <= 0; a_done_cnt <= 0; a_done_cyc <= 0; a_viol <= 0;
        end else begin
            if (!a_kcsb1 && !a_kweb1) begin a_km[a_kadd1] <= a_kd1; a_kcnt <= a_kcnt + 1; end
            if (!a_kcsb2 && !a_kweb2) a_km[a_kadd2] <= a_kd2;
            if (!a_wcsb1 && !a_wweb1) begin
                a_w1[a_wadd1] <= a_w1d1; a_w2[a_wadd1] <= a_w2d1;
                a_wcnt[a_wadd1] <= a_wcnt[a_wadd1] + 1; a_wtot <= a_wtot + 1; a_last_w <= cyc_cnt;
            end
            if (!a_wcsb2 && !a_wweb2) begin
                a_w1[a_wadd2] <= a_w1d2; a_w2[a_wadd2] <= a_w2d2;
                a_wcnt[a_wadd2] <= a_wcnt[a_wadd2] + 1;
            end
            if (a_done) begin a_done_cnt <= a_done_cnt + 1; a_done_cyc <= cyc_cnt; end
            if (!(a_koeb1 && a_koeb2 && a_woeb1 && a_woeb2) || (!a_kcsb1 && !a_wcsb1) || (a_done && a_busy))
                a_viol <= a_viol + 1;
        end
    end

    always @(posedge clk) begin
        if (mdl_clr) begin
            for (int i = 0; i < 32; i++) begin
                b_km[i] <= '0; b_w1[i] <= '0; b_w2[i] <= '0; b_wcnt[i] <= 0;
            end
            b_kcnt <= 0; b_wtot <= 0; b_last_w <= 0; b_done_cnt <= 0; b_done_cyc <= 0; b_viol <= 0;
        end else begin
            if (!b_kcsb1 && !b_kweb1) begin b_km[b_kadd1] <= b_kd1; b_kcnt <= b_kcnt + 1; end
            if (!b_kcsb2 && !b_kweb2) b_km[b_kadd2] <= b_kd2;
            if (!b_wcsb1 && !b_wweb1) begin
                b_w1[b_wadd1] <= b_w1d1; b_w2[b_wadd1] <= b_w2d1;
                b_wcnt[b_wadd1] <= b_wcnt[b_wadd1] + 1; b_wtot <= b_wtot + 1; b_last_w <= cyc_cnt;
            end
            if (!b_wcsb2 && !b_wweb2) begin
                b_w1[b_wadd2] <= b_w1d2; b_w2[b_wadd2] <= b_w2d2;
                b_wcnt[b_wadd2] <= b_wcnt[b_wadd2] + 1;
            end
            if (b_done) begin b_done_cnt <= b_done_cnt + 1; b_done_cyc <= cyc_cnt; end
            if (!(b_koeb1 && b_koeb2 && b_woeb1 && b_woeb2) || (!b_kcsb1 && !b_wcsb1) || (b_done && b_busy))
                b_viol <= b_viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clr_models();
        mdl_clr = 1'b1;
        @(posedge clk); #1;
        mdl_clr = 1'b0;
    endtask

    // Streams nwords words base+i; optional mid-load start pulse; optionally waits for done.
    task automatic feed(input bit sb, input int nwords, input bit toggle, input logic [31:0] base,
                        input int start_mid_at, input bit wait_done, output int cycles);
        int  idx = 0;
        int  cyc = 0;
        bit  b;
        bit  got = 0;
        sel_b = sb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (idx < nwords && cyc < 2000) begin
            valid = toggle ? (cyc % 2 == 0) : 1'b1;
            data  = base + idx;
            start = (cyc == start_mid_at);
            @(negedge clk);
            b = valid && (sb ? b_ready : a_ready);
            @(posedge clk); #1;
            if (b) idx++;
            cyc++;
        end
        valid = 1'b0;
        start = 1'b0;
        chk("feed_words", idx, nwords);
        if (wait_done) begin
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (sb ? b_done : a_done) begin got = 1; break; end
                @(posedge clk); #1;
                cyc++;
            end
            @(posedge clk); #1;
            chk("done_seen", got, 1);
        end
        cycles = cyc;
    endtask

    task automatic chk_load(input bit sb, input logic [31:0] base, input int w_wr);
        int bad = 0;
        chk("kmem0", sb ? b_km[0] : a_km[0], base);
        chk("kmem1", sb ? b_km[1] : a_km[1], base + 1);
        for (int k = 0; k < w_wr; k++) begin
            chk($sformatf("w1_%0d", 2*k),   sb ? b_w1[2*k]   : a_w1[2*k],   base + 2 + 4*k);
            chk($sformatf("w1_%0d", 2*k+1), sb ? b_w1[2*k+1] : a_w1[2*k+1], base + 3 + 4*k);
            chk($sformatf("w2_%0d", 2*k),   sb ? b_w2[2*k]   : a_w2[2*k],   base + 4 + 4*k);
            chk($sformatf("w2_%0d", 2*k+1), sb ? b_w2[2*k+1] : a_w2[2*k+1], base + 5 + 4*k);
        end
        for (int i = 0; i < 32; i++) begin
            if ((sb ? b_wcnt[i] : a_wcnt[i]) != ((i < 2*w_wr) ? 1 : 0)) bad++;
        end
        chk("wmem_addr_once", bad, 0);
        chk("kmem_writes", sb ? b_kcnt : a_kcnt, 1);
        chk("done_count", sb ? b_done_cnt : a_done_cnt, 1);
        chk("done_latency", sb ? (b_done_cyc - b_last_w) : (a_done_cyc - a_last_w), 1);
        chk("protocol_viol", sb ? b_viol : a_viol, 0);
    endtask

    initial begin
        int  c2, c3, cx;
        bit  seen;

        // 1. reset values
        rst = 1'b1;
        mdl_clr = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        mdl_clr = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", a_ready, 0);
        chk("rst_busy",  a_busy, 0);
        chk("rst_done",  a_done, 0);
        chk("rst_kcsb1", a_kcsb1, 1);
        chk("rst_kweb2", a_kweb2, 1);
        chk("rst_wcsb2", a_wcsb2, 1);
        chk("rst_woeb1", a_woeb1, 1);
        chk("rst_kadd2", a_kadd2, 0);
        chk("rst_wadd2", a_wadd2, 0);

        // 2. continuous stream
        clr_models();
        feed(0, 10, 0, 32'h1000_0000, -1, 1, c2);
        chk_load(0, 32'h1000_0000, 2);

        // 3. toggling valid
        clr_models();
        feed(0, 10, 1, 32'h1000_0000, -1, 1, c3);
        chk_load(0, 32'h1000_0000, 2);
        chk("toggle_slower", c3 > c2, 1);

        // 4. start while busy, valid while idle
        clr_models();
        feed(0, 10, 0, 32'h3000_0000, 3, 1, cx);
        seen = 0;
        valid = 1'b1;
        data = 32'hDEAD_BEEF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_ready || a_busy) seen = 1;
            @(posedge clk); #1;
        end
        valid = 1'b0;
        chk("idle_ready", seen, 0);
        chk_load(0, 32'h3000_0000, 2);

        // 5. reset after the third weight beat
        clr_models();
        feed(0, 5, 0, 32'h4000_0000, -1, 0, cx);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready", a_ready, 0);
        chk("abort_busy",  a_busy, 0);
        chk("abort_wcsb1", a_wcsb1, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_no_wmem", a_wtot, 0);
        chk("abort_kmem", a_kcnt, 1);
        clr_models();
        feed(0, 10, 0, 32'h2000_0000, -1, 1, cx);
        chk_load(0, 32'h2000_0000, 2);

        // 6. full W_WR=16 load
        clr_models();
        feed(1, 66, 0, 32'h5000_0000, -1, 1, cx);
        chk_load(1, 32'h5000_0000, 16);
        chk("last_w1_30", b_w1[30], 32'h5000_0000 + 2 + 4*15);
        chk("last_w2_31", b_w2[31], 32'h5000_0000 + 5 + 4*15);
        chk("a_idle_during_b", a_done_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
